// File: rtl/queue_access_ctrl_if.sv
// rtl/queue_access_ctrl_if.sv - producer/consumer/queue-side signal bundle for queue_access_ctrl
interface queue_access_ctrl_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int AW   = 10
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               deq_req;
    logic               deq_valid;
    logic [DW-1:0]      deq_data;
    logic               flush;
    logic               flush_busy;
    logic               q_enqueue;
    logic               q_dequeue;
    logic [DW-1:0]      q_in;
    logic [DW-1:0]      q_out;
    logic [AW:0]        count;
    logic               full;
    logic               empty;

    modport master (
        output req_valid, req_data, deq_req, flush, q_out,
        input  req_ready, deq_valid, deq_data, flush_busy,
               q_enqueue, q_dequeue, q_in, count, full, empty
    );

    modport slave (
        input  req_valid, req_data, deq_req, flush, q_out,
        output req_ready, deq_valid, deq_data, flush_busy,
               q_enqueue, q_dequeue, q_in, count, full, empty
    );
endinterface

// File: rtl/queue_access_ctrl.sv
// rtl/queue_access_ctrl.sv - round-robin producer arbitration, enq/deq alternation and flush for a shared FIFO
module queue_access_ctrl #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int AW   = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    queue_access_ctrl_if.slave bus
);
    localparam int          PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [AW:0] DEPTH   = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic {ST_RUN, ST_FLUSH} state_e;
    typedef enum logic {OP_ENQ, OP_DEQ} op_e;

    state_e        state_q, state_d;
    op_e           last_op_q, last_op_d;
    logic [AW:0]   count_q, count_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic          deq_valid_q, deq_valid_d;

    logic [PW-1:0] winner;
    logic [PW-1:0] scan_idx;
    logic          found;
    logic          full, empty, in_run;
    logic          can_enq, can_deq, do_enq, do_deq;

    // First requester at or after rr_ptr, wrapping through NREQ-1 back to 0.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = PW'((int'(rr_ptr_q) + k) % NREQ);
            if (!found && bus.req_valid[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
    end

    // Queue strobes are gated by rst_n so nothing reaches the queue while it is held in reset.
    always_comb begin
        full    = (count_q == DEPTH);
        empty   = (count_q == '0);
        in_run  = (state_q == ST_RUN);
        can_enq = in_run && (|bus.req_valid) && !full;
        can_deq = in_run && bus.deq_req && !empty;
        do_enq  = rst_n && can_enq && (!can_deq || (last_op_q == OP_DEQ));
        do_deq  = rst_n && ((can_deq && !do_enq) || (!in_run && !empty));

        bus.req_ready = '0;
        bus.q_in      = '0;
        if (do_enq) begin
            bus.req_ready[winner] = 1'b1;
            bus.q_in              = bus.req_data[int'(winner)*DW +: DW];
        end
        bus.q_enqueue = do_enq;
        bus.q_dequeue = do_deq;
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rr_ptr_d    = rr_ptr_q;
        last_op_d   = last_op_q;
        deq_valid_d = 1'b0;

        if (do_enq) begin
            count_d   = count_q + CNT_ONE;
            rr_ptr_d  = PW'((int'(winner) + 1) % NREQ);
            last_op_d = OP_ENQ;
        end else if (do_deq) begin
            count_d = count_q - CNT_ONE;
            // Flush drains are silent and do not disturb the alternation history.
            if (in_run) begin
                last_op_d   = OP_DEQ;
                deq_valid_d = 1'b1;
            end
        end

        case (state_q)
            ST_RUN:   if (bus.flush) state_d = ST_FLUSH;
            ST_FLUSH: if (empty) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            count_q     <= '0;
            rr_ptr_q    <= '0;
            last_op_q   <= OP_ENQ;
            deq_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rr_ptr_q    <= rr_ptr_d;
            last_op_q   <= last_op_d;
            deq_valid_q <= deq_valid_d;
        end
    end

    assign bus.deq_valid  = deq_valid_q;
    assign bus.deq_data   = bus.q_out;
    assign bus.flush_busy = (state_q == ST_FLUSH);
    assign bus.count      = count_q;
    assign bus.full       = full;
    assign bus.empty      = empty;
endmodule
